// File: rtl/axi_sram_bridge_mp_pkg.sv
// Shared AXI3 constants and write-FSM state encoding for the SRAM bridge.
// Optional macro AXI_BRIDGE_RESP_ERR_EN is consumed by axi_sram_bridge_mp.
package axi_bridge_pkg;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    typedef logic [1:0] wstate_t;

    localparam wstate_t W_IDLE = 2'd0;
    localparam wstate_t W_SEND = 2'd1;
    localparam wstate_t W_RESP = 2'd2;

endpackage

// File: rtl/axi_sram_bridge_mp_if.sv
// AXI3 master bus bundle between the SRAM bridge and the interconnect.
// master = bridge side, slave = interconnect / memory side.
interface axi_sram_bridge_mp_if #(
    parameter int ID_WIDTH = 4
);

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_sram_bridge_mp_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins.
// nxt points one past the winner so it gets lowest priority next time.
module rr_arb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        nxt   = ptr;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            for (int p = 0; p < N; p++) begin
                if (!found && p == pos && req[p]) begin
                    found  = 1'b1;
                    gnt[p] = 1'b1;
                    nxt    = (p == N - 1) ? '0 : PW'(p + 1);
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge: RR read/write arbitration, AXI id = port.
// Define AXI_BRIDGE_RESP_ERR_EN to add sram_data_err for non-OKAY responses.
module axi_sram_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_PORTS-1:0]    sram_req,
    input  logic [NUM_PORTS-1:0]    sram_wr,
    input  logic [2*NUM_PORTS-1:0]  sram_size,
    input  logic [4*NUM_PORTS-1:0]  sram_wstrb,
    input  logic [32*NUM_PORTS-1:0] sram_addr,
    input  logic [32*NUM_PORTS-1:0] sram_wdata,
    output logic [NUM_PORTS-1:0]    sram_addr_ok,
    output logic [NUM_PORTS-1:0]    sram_data_ok,
    output logic [32*NUM_PORTS-1:0] sram_rdata,
`ifdef AXI_BRIDGE_RESP_ERR_EN
    output logic [NUM_PORTS-1:0]    sram_data_err,
`endif
    axi_sram_bridge_mp_if.master    axi
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
    logic [31:0]         ar_addr_q, ar_addr_d;
    logic [1:0]          ar_size_q, ar_size_d;
    logic                arvalid_q, arvalid_d;

    wstate_t             wstate_q, wstate_d;
    logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
    logic [31:0]         aw_addr_q, aw_addr_d;
    logic [1:0]          aw_size_q, aw_size_d;
    logic [3:0]          w_strb_q, w_strb_d;
    logic [31:0]         w_data_q, w_data_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;

    logic [NUM_PORTS-1:0] rd_haz, rd_elig, rd_req, rd_gnt;
    logic [NUM_PORTS-1:0] wr_req, wr_gnt;
    logic [NUM_PORTS-1:0] r_hit, b_hit;
    logic                 ar_free, bready;

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = {1'b0, ar_size_q};
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = AXI_LOCK_NORMAL;
    assign axi.arcache = AXI_CACHE_NONE;
    assign axi.arprot  = AXI_PROT_NONE;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = 1'b1;

    assign axi.awid    = aw_id_q;
    assign axi.awaddr  = aw_addr_q;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = {1'b0, aw_size_q};
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = AXI_LOCK_NORMAL;
    assign axi.awcache = AXI_CACHE_NONE;
    assign axi.awprot  = AXI_PROT_NONE;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = aw_id_q;
    assign axi.wdata   = w_data_q;
    assign axi.wstrb   = w_strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready;

    assign bready  = (wstate_q == W_RESP);
    assign ar_free = !arvalid_q || axi.arready;

    // A read may not overtake the in-flight write to the same word.
    always_comb begin
        rd_haz  = '0;
        rd_elig = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_haz[p]  = (wstate_q != W_IDLE) &&
                         (aw_addr_q[31:2] == sram_addr[p*32+2 +: 30]);
            rd_elig[p] = sram_req[p] && !sram_wr[p] && !rd_haz[p] &&
                         (cnt_q[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    assign rd_req = rd_elig & {NUM_PORTS{ar_free}};
    assign wr_req = sram_req & sram_wr & {NUM_PORTS{wstate_q == W_IDLE}};

    rr_arb #(.N(NUM_PORTS), .PW(PTR_W)) u_rd_arb (
        .req (rd_req),
        .ptr (rd_ptr_q),
        .gnt (rd_gnt),
        .nxt (rd_ptr_nxt)
    );

    rr_arb #(.N(NUM_PORTS), .PW(PTR_W)) u_wr_arb (
        .req (wr_req),
        .ptr (wr_ptr_q),
        .gnt (wr_gnt),
        .nxt (wr_ptr_nxt)
    );

    always_comb begin
        r_hit = '0;
        b_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            r_hit[p] = axi.rvalid && (axi.rid == ID_WIDTH'(p));
            b_hit[p] = axi.bvalid && bready && (axi.bid == ID_WIDTH'(p));
        end
    end

    assign sram_addr_ok = rd_gnt | wr_gnt;
    assign sram_data_ok = r_hit | b_hit;

    always_comb begin
        sram_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_hit[p]) sram_rdata[p*32 +: 32] = axi.rdata;
        end
    end

`ifdef AXI_BRIDGE_RESP_ERR_EN
    always_comb begin
        sram_data_err = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sram_data_err[p] = (r_hit[p] && axi.rresp != AXI_RESP_OKAY) ||
                               (b_hit[p] && axi.bresp != AXI_RESP_OKAY);
        end
    end

    logic unused_in;
    assign unused_in = axi.rlast;
`else
    logic unused_in;
    assign unused_in = ^{axi.rlast, axi.rresp, axi.bresp};
`endif

    always_comb begin
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        arvalid_d = arvalid_q && !axi.arready;
        rd_ptr_d  = rd_ptr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_gnt[p]) begin
                ar_id_d   = ID_WIDTH'(p);
                ar_addr_d = sram_addr[p*32 +: 32];
                ar_size_d = sram_size[p*2 +: 2];
                arvalid_d = 1'b1;
                rd_ptr_d  = rd_ptr_nxt;
            end
        end
    end

    // Spurious returns with no read outstanding must not wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(rd_gnt[p]) -
                       CNT_W'(r_hit[p] && cnt_q[p] != '0);
        end
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_id_d   = aw_id_q;
        aw_addr_d = aw_addr_q;
        aw_size_d = aw_size_q;
        w_strb_d  = w_strb_q;
        w_data_d  = w_data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wr_ptr_d  = wr_ptr_q;
        case (wstate_q)
            W_IDLE: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (wr_gnt[p]) begin
                        aw_id_d   = ID_WIDTH'(p);
                        aw_addr_d = sram_addr[p*32 +: 32];
                        aw_size_d = sram_size[p*2 +: 2];
                        w_strb_d  = sram_wstrb[p*4 +: 4];
                        w_data_d  = sram_wdata[p*32 +: 32];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wr_ptr_d  = wr_ptr_nxt;
                        wstate_d  = W_SEND;
                    end
                end
            end
            W_SEND: begin
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) wstate_d = W_RESP;
            end
            W_RESP: begin
                if (axi.bvalid) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            arvalid_q <= 1'b0;
            wstate_q  <= W_IDLE;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_strb_q  <= '0;
            w_data_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            arvalid_q <= arvalid_d;
            wstate_q  <= wstate_d;
            aw_id_q   <= aw_id_d;
            aw_addr_q <= aw_addr_d;
            aw_size_q <= aw_size_d;
            w_strb_q  <= w_strb_d;
            w_data_q  <= w_data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp (2 ports, MAX_OUTSTANDING 4).
// Build with AXI_BRIDGE_RESP_ERR_EN defined to cover sram_data_err.
module tb_axi_sram_bridge_mp;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  sram_req;
    logic [1:0]  sram_wr;
    logic [3:0]  sram_size;
    logic [7:0]  sram_wstrb;
    logic [63:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [1:0]  sram_addr_ok;
    logic [1:0]  sram_data_ok;
    logic [63:0] sram_rdata;
`ifdef AXI_BRIDGE_RESP_ERR_EN
    logic [1:0]  sram_data_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int hits;

    axi_sram_bridge_mp_if #(.ID_WIDTH(4)) bus ();

    axi_sram_bridge_mp #(
        .NUM_PORTS       (2),
        .ID_WIDTH        (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .sram_req      (sram_req),
        .sram_wr       (sram_wr),
        .sram_size     (sram_size),
        .sram_wstrb    (sram_wstrb),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_addr_ok  (sram_addr_ok),
        .sram_data_ok  (sram_data_ok),
        .sram_rdata    (sram_rdata),
`ifdef AXI_BRIDGE_RESP_ERR_EN
        .sram_data_err (sram_data_err),
`endif
        .axi           (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        sram_req    = '0;
        sram_wr     = '0;
        sram_size   = 4'b1010;
        sram_wstrb  = '0;
        sram_addr   = '0;
        sram_wdata  = '0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b1;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and constant outputs
        do_reset();
        #1;
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_addr_ok", sram_addr_ok, 0);
        check("rst_data_ok", sram_data_ok, 0);
        check("rst_rdata", sram_rdata, 0);
        check("const_rready", bus.rready, 1);
        check("const_wlast", bus.wlast, 1);
        check("const_arburst", bus.arburst, 1);
        check("const_arlen", bus.arlen, 0);
`ifdef AXI_BRIDGE_RESP_ERR_EN
        check("rst_data_err", sram_data_err, 0);
`endif

        // 1: single read on port 0
        sram_req = 2'b01;
        sram_addr[31:0] = 32'h1C00_0000;
        bus.arready = 1'b1;
        #1 check("t1_addr_ok", sram_addr_ok, 2'b01);
        step();
        sram_req = '0;
        #1;
        check("t1_arvalid", bus.arvalid, 1);
        check("t1_arid", bus.arid, 0);
        check("t1_araddr", bus.araddr, 64'h1C00_0000);
        check("t1_arsize", bus.arsize, 3'b010);
        step();
        #1 check("t1_ar_drop", bus.arvalid, 0);
        step();
        bus.rvalid = 1'b1;
        bus.rid    = 4'd0;
        bus.rdata  = 32'hDEAD_BEEF;
        #1;
        check("t1_data_ok", sram_data_ok, 2'b01);
        check("t1_rdata", sram_rdata, 64'h0000_0000_DEAD_BEEF);
        step();
        bus.rvalid = 1'b0;
        #1 check("t1_idle_rdata", sram_rdata, 0);

        // 2: both ports read every cycle, grants alternate from port 0
        do_reset();
        sram_req  = 2'b11;
        sram_addr = {32'h200, 32'h100};
        bus.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_addr_ok", sram_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) check("t2_arid", bus.arid, (i - 1) % 2);
            step();
        end
        sram_req = '0;
        #1;
        check("t2_arid_last", bus.arid, 1);
        check("t2_araddr_last", bus.araddr, 64'h200);
        step();
        bus.rvalid = 1'b1;
        bus.rid    = 4'd1;
        bus.rdata  = 32'h1111_1111;
        #1;
        check("t2_ooo_ok1", sram_data_ok, 2'b10);
        check("t2_ooo_rd1", sram_rdata, 64'h1111_1111_0000_0000);
        step();
        bus.rid   = 4'd0;
        bus.rdata = 32'h2222_2222;
        #1;
        check("t2_ooo_ok0", sram_data_ok, 2'b01);
        check("t2_ooo_rd0", sram_rdata, 64'h0000_0000_2222_2222);
        step();
        bus.rvalid = 1'b0;

        // 3: outstanding limit on port 1
        do_reset();
        sram_req = 2'b10;
        sram_addr[63:32] = 32'h300;
        bus.arready = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (sram_addr_ok[1]) hits++;
            step();
        end
        check("t3_accepted", hits, 4);
        #1 check("t3_stall", sram_addr_ok, 0);
        bus.rvalid = 1'b1;
        bus.rid    = 4'd1;
        #1;
        check("t3_ret_ok", sram_data_ok, 2'b10);
        check("t3_ret_stall", sram_addr_ok, 0);
        step();
        bus.rvalid = 1'b0;
        #1 check("t3_resume", sram_addr_ok, 2'b10);
        sram_req = '0;
        step();

        // 4: port 1 write with late wready and read hazard on port 0
        do_reset();
        bus.arready = 1'b1;
        sram_req = 2'b10;
        sram_wr  = 2'b10;
        sram_addr[63:32]  = 32'h80;
        sram_wstrb[7:4]   = 4'b0011;
        sram_wdata[63:32] = 32'hCAFE_F00D;
        #1 check("t4_w_addr_ok", sram_addr_ok, 2'b10);
        step();
        sram_req = 2'b01;
        sram_wr  = '0;
        sram_addr[31:0] = 32'h80;
        bus.awready = 1'b1;
        #1;
        check("t4_awvalid", bus.awvalid, 1);
        check("t4_wvalid", bus.wvalid, 1);
        check("t4_awid", bus.awid, 1);
        check("t4_wid", bus.wid, 1);
        check("t4_awaddr", bus.awaddr, 64'h80);
        check("t4_awsize", bus.awsize, 3'b010);
        check("t4_wstrb", bus.wstrb, 4'b0011);
        check("t4_wdata", bus.wdata, 64'hCAFE_F00D);
        check("t4_haz_80", sram_addr_ok, 0);
        step();
        bus.awready = 1'b0;
        sram_addr[31:0] = 32'h84;
        #1;
        check("t4_aw_done", bus.awvalid, 0);
        check("t4_w_pend", bus.wvalid, 1);
        check("t4_no_bready", bus.bready, 0);
        check("t4_rd_84", sram_addr_ok, 2'b01);
        step();
        sram_addr[31:0] = 32'h80;
        #1 check("t4_haz_80b", sram_addr_ok, 0);
        step();
        bus.wready = 1'b1;
        #1;
        check("t4_w_wait", bus.wvalid, 1);
        check("t4_send_bready", bus.bready, 0);
        step();
        bus.wready = 1'b0;
        bus.bvalid = 1'b1;
        bus.bid    = 4'd1;
        #1;
        check("t4_w_done", bus.wvalid, 0);
        check("t4_bready", bus.bready, 1);
        check("t4_haz_resp", sram_addr_ok, 0);
        check("t4_b_ok", sram_data_ok, 2'b10);
        step();
        bus.bvalid = 1'b0;
        #1;
        check("t4_idle_bready", bus.bready, 0);
        check("t4_rd_80_free", sram_addr_ok, 2'b01);
        sram_req = '0;
        step();

        // 5: reset mid-transaction
        do_reset();
        bus.arready = 1'b1;
        sram_req  = 2'b11;
        sram_wr   = 2'b10;
        sram_addr = {32'h40, 32'h10};
        #1 check("t5_dual_grant", sram_addr_ok, 2'b11);
        step();
        sram_req = 2'b01;
        sram_wr  = '0;
        sram_addr[31:0] = 32'h14;
        #1 check("t5_rd2", sram_addr_ok, 2'b01);
        step();
        sram_req = '0;
        #1;
        check("t5_pre_awvalid", bus.awvalid, 1);
        check("t5_pre_arvalid", bus.arvalid, 1);
        aresetn = 1'b0;
        #1;
        check("t5_arvalid", bus.arvalid, 0);
        check("t5_awvalid", bus.awvalid, 0);
        check("t5_wvalid", bus.wvalid, 0);
        check("t5_bready", bus.bready, 0);
        step();
        step();
        aresetn = 1'b1;
        sram_req  = 2'b11;
        sram_wr   = 2'b10;
        sram_addr = {32'h40, 32'h20};
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (sram_addr_ok[0]) hits++;
            if (i == 0) check("t5_w_accept", sram_addr_ok[1], 1);
            step();
            sram_req[1] = 1'b0;
        end
        check("t5_rd_accepted", hits, 4);
        #1 check("t5_post_awvalid", bus.awvalid, 1);
        sram_req = '0;
        step();

`ifdef AXI_BRIDGE_RESP_ERR_EN
        // 6: error response flagged with data_ok
        do_reset();
        bus.rvalid = 1'b1;
        bus.rid    = 4'd0;
        bus.rresp  = 2'b10;
        bus.rdata  = 32'h5A5A_5A5A;
        #1;
        check("t6_data_ok", sram_data_ok, 2'b01);
        check("t6_data_err", sram_data_err, 2'b01);
        step();
        bus.rresp = 2'b00;
        #1 check("t6_okay_err", sram_data_err, 0);
        step();
        bus.rvalid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
